// File: rtl/flex_counter_ud.sv
// Parametrised up/down counter with load, wrap/saturate mode
// and registered terminal, zero, wrap and saturation status.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS = 4,
    parameter bit SATURATE     = 1'b0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    count_up,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    zero_flag,
    output logic                    wrap_pulse,
    output logic                    sat_flag
);

    localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] ONE  = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_roll;
    logic                    r_zero;
    logic                    r_wrap;
    logic                    r_sat;

    logic [NUM_CNT_BITS-1:0] w_next;
    logic                    w_wrap;
    logic                    w_sat;
    logic                    w_at_top;
    logic                    w_above;

    assign w_at_top = (r_count >= rollover_val);
    assign w_above  = (r_count > rollover_val);

    // Limit checks come first so +1/-1 can never overflow the register.
    always_comb begin
        w_next = r_count;
        w_wrap = 1'b0;
        w_sat  = 1'b0;
        if (clear) begin
            w_next = ZERO;
        end else if (load) begin
            w_next = load_val;
        end else if (count_enable) begin
            if (rollover_val == ZERO) begin
                w_next = ZERO;
            end else if (count_up) begin
                if (!w_at_top) begin
                    w_next = r_count + ONE;
                end else if (SATURATE) begin
                    w_next = rollover_val;
                    w_sat  = 1'b1;
                end else begin
                    w_next = ONE;
                    w_wrap = 1'b1;
                end
            end else begin
                if (w_above) begin
                    w_next = rollover_val;
                end else if (r_count != ZERO) begin
                    w_next = r_count - ONE;
                end else if (SATURATE) begin
                    w_next = ZERO;
                    w_sat  = 1'b1;
                end else begin
                    w_next = rollover_val;
                    w_wrap = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= ZERO;
            r_roll  <= 1'b0;
            r_zero  <= 1'b1;
            r_wrap  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_roll  <= (w_next == rollover_val);
            r_zero  <= (w_next == ZERO);
            r_wrap  <= w_wrap;
            r_sat   <= w_sat;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_roll;
    assign zero_flag     = r_zero;
    assign wrap_pulse    = r_wrap;
    assign sat_flag      = r_sat;

endmodule

// File: tb/tb_flex_counter_ud.sv
// Bench for flex_counter_ud: wrap and saturate instances share
// stimulus and are compared every cycle with an arithmetic model.
module tb_flex_counter_ud;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       count_enable;
    logic       count_up;
    logic [3:0] rollover_val;

    logic [3:0] cnt_w, cnt_s;
    logic       rf_w, rf_s, zf_w, zf_s, wp_w, wp_s, sf_w, sf_s;

    int n_chk  = 0;
    int n_pass = 0;

    int m_cnt [2];
    bit m_rf  [2];
    bit m_zf  [2];
    bit m_wp  [2];
    bit m_sf  [2];

    always #5 clk = ~clk;

    flex_counter_ud #(.NUM_CNT_BITS(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
        .load_val(load_val), .count_enable(count_enable),
        .count_up(count_up), .rollover_val(rollover_val),
        .count_out(cnt_w), .rollover_flag(rf_w), .zero_flag(zf_w),
        .wrap_pulse(wp_w), .sat_flag(sf_w)
    );

    flex_counter_ud #(.NUM_CNT_BITS(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
        .load_val(load_val), .count_enable(count_enable),
        .count_up(count_up), .rollover_val(rollover_val),
        .count_out(cnt_s), .rollover_flag(rf_s), .zero_flag(zf_s),
        .wrap_pulse(wp_s), .sat_flag(sf_s)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_rf[k]  = 0;
            m_zf[k]  = 1;
            m_wp[k]  = 0;
            m_sf[k]  = 0;
        end
    endtask

    // Model of one edge, straight from the counting rules.
    task automatic model_edge();
        int r;
        r = int'(rollover_val);
        for (int k = 0; k < 2; k++) begin
            int  c;
            bit  sat;
            c   = m_cnt[k];
            sat = (k == 1);
            m_wp[k] = 0;
            m_sf[k] = 0;
            if (clear) c = 0;
            else if (load) c = int'(load_val);
            else if (count_enable) begin
                if (r == 0) c = 0;
                else if (count_up) begin
                    if (c < r) c = c + 1;
                    else if (sat) begin c = r; m_sf[k] = 1; end
                    else begin c = 1; m_wp[k] = 1; end
                end else begin
                    if (c > r) c = r;
                    else if (c > 0) c = c - 1;
                    else if (sat) m_sf[k] = 1;
                    else begin c = r; m_wp[k] = 1; end
                end
            end
            m_cnt[k] = c;
            m_rf[k]  = (c == r);
            m_zf[k]  = (c == 0);
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, "_cnt_w"}, int'(cnt_w), m_cnt[0]);
        check({ph, "_rf_w"}, int'(rf_w), int'(m_rf[0]));
        check({ph, "_zf_w"}, int'(zf_w), int'(m_zf[0]));
        check({ph, "_wp_w"}, int'(wp_w), int'(m_wp[0]));
        check({ph, "_sf_w"}, int'(sf_w), int'(m_sf[0]));
        check({ph, "_cnt_s"}, int'(cnt_s), m_cnt[1]);
        check({ph, "_rf_s"}, int'(rf_s), int'(m_rf[1]));
        check({ph, "_zf_s"}, int'(zf_s), int'(m_zf[1]));
        check({ph, "_wp_s"}, int'(wp_s), int'(m_wp[1]));
        check({ph, "_sf_s"}, int'(sf_s), int'(m_sf[1]));
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ph);
    endtask

    task automatic idle();
        clear = 0; load = 0; count_enable = 0; count_up = 1;
    endtask

    task automatic do_reset();
        n_rst = 0;
        #1;
        model_reset();
        compare_all("rst");
        @(negedge clk);
        n_rst = 1;
    endtask

    task automatic load_now(input int v, input int r);
        idle();
        load = 1; load_val = 4'(v); rollover_val = 4'(r);
        tick("ld");
        load = 0;
    endtask

    int exp_up[12] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
    int exp_dn[5]  = '{2, 1, 0, 5, 4};
    int exp_su[6]  = '{1, 2, 3, 4, 4, 4};
    int exp_sd[6]  = '{3, 2, 1, 0, 0, 0};

    initial begin
        n_rst = 1; idle(); load_val = 0; rollover_val = 5;
        #2;
        do_reset();

        // 1: wrap sequence going up
        rollover_val = 5; count_enable = 1; count_up = 1;
        for (int i = 0; i < 12; i++) begin
            tick("t1");
            check("t1_cnt", int'(cnt_w), exp_up[i]);
            check("t1_rf", int'(rf_w), int'(exp_up[i] == 5));
            check("t1_wp", int'(wp_w), int'(i == 5 || i == 10));
        end

        // 2: load then count down through zero
        load_now(3, 5);
        check("t2_load", int'(cnt_w), 3);
        count_enable = 1; count_up = 0;
        for (int i = 0; i < 5; i++) begin
            tick("t2");
            check("t2_cnt", int'(cnt_w), exp_dn[i]);
            check("t2_zf", int'(zf_w), int'(exp_dn[i] == 0));
            check("t2_wp", int'(wp_w), int'(i == 3));
        end

        // 3: saturating instance
        do_reset();
        rollover_val = 4; count_enable = 1; count_up = 1;
        for (int i = 0; i < 6; i++) begin
            tick("t3u");
            check("t3u_cnt", int'(cnt_s), exp_su[i]);
            check("t3u_sf", int'(sf_s), int'(i >= 4));
        end
        count_up = 0;
        for (int i = 0; i < 6; i++) begin
            tick("t3d");
            check("t3d_cnt", int'(cnt_s), exp_sd[i]);
            check("t3d_sf", int'(sf_s), int'(i >= 4));
        end

        // 4: priority
        load_now(3, 9);
        clear = 1; load = 1; load_val = 7; count_enable = 1; count_up = 1;
        tick("t4a");
        check("t4_clr_cnt", int'(cnt_w), 0);
        check("t4_clr_zf", int'(zf_w), 1);
        clear = 0;
        tick("t4b");
        check("t4_ld_cnt", int'(cnt_w), 7);

        // 5: limit lowered below the count
        load_now(7, 9);
        rollover_val = 4; count_enable = 1; count_up = 1;
        tick("t5a");
        check("t5_up_cnt", int'(cnt_w), 1);
        check("t5_up_wp", int'(wp_w), 1);
        check("t5_up_sat", int'(cnt_s), 4);
        load_now(7, 9);
        rollover_val = 4; count_enable = 1; count_up = 0;
        tick("t5b");
        check("t5_dn_cnt", int'(cnt_w), 4);
        check("t5_dn_rf", int'(rf_w), 1);
        check("t5_dn_wp", int'(wp_w), 0);
        load_now(7, 9);
        rollover_val = 0; count_enable = 1; count_up = 1;
        tick("t5c");
        check("t5_r0_cnt", int'(cnt_w), 0);
        check("t5_r0_rf", int'(rf_w), 1);
        check("t5_r0_zf", int'(zf_w), 1);

        // 6: asynchronous reset mid-count
        load_now(6, 9);
        @(negedge clk);
        #2;
        n_rst = 0;
        #1;
        model_reset();
        check("t6_cnt", int'(cnt_w), 0);
        check("t6_zf", int'(zf_w), 1);
        compare_all("t6");
        @(negedge clk);
        n_rst = 1;
        count_enable = 1; count_up = 1; rollover_val = 9;
        tick("t6b");
        check("t6_first", int'(cnt_w), 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            clear        = ($urandom_range(0, 15) == 0);
            load         = ($urandom_range(0, 7) == 0);
            load_val     = 4'($urandom);
            count_enable = ($urandom_range(0, 3) != 0);
            count_up     = 1'($urandom);
            if ($urandom_range(0, 9) == 0)
                rollover_val = 4'($urandom);
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
